// File: rtl/sw_input_periph_pkg.sv
//============================================================================
// Module : sw_input_periph_pkg
// Brief  : Register map and control-bit constants for the switch input
//          peripheral, plus a helper that packs the CTRL read word.
//          Optional feature macro: SW_INPUT_CHG_CNT_EN.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package sw_input_periph_pkg;

  // Register word addresses
  localparam logic [1:0] SW_REG_VALUE = 2'd0;
  localparam logic [1:0] SW_REG_CTRL  = 2'd1;
  localparam logic [1:0] SW_REG_RAW   = 2'd2;
  localparam logic [1:0] SW_REG_CNT   = 2'd3;

  // CTRL register bit positions
  localparam int SW_CTRL_CHG = 0;
  localparam int SW_CTRL_IE  = 1;

  // Pack {ie, chg} into a zero-extended 32-bit read word
  function automatic logic [31:0] ctrl_word(input logic ie, input logic chg);
    logic [31:0] w;
    w              = '0;
    w[SW_CTRL_IE]  = ie;
    w[SW_CTRL_CHG] = chg;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_input_periph_debounce.sv
//============================================================================
// Module : sw_debounce
// Brief  : Two-flop synchroniser, persistence counter and stable register.
//          accept_o is high in the cycle whose closing edge loads stable.
//          Optional feature macro: SW_INPUT_CHG_CNT_EN (not used here).
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module sw_debounce #(
  parameter int SW_W       = 10,
  parameter int DEB_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] sync_o,
  output logic [SW_W-1:0] stable_o,
  output logic            accept_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;

  assign w_differs = (r_sync2 != r_stable);
  // The counter does not restart when the pending value changes mid-count;
  // whatever sync2 holds at the acceptance edge is what gets loaded.
  assign accept_o  = w_differs && (r_cnt == C_CNT_LAST);
  assign sync_o    = r_sync2;
  assign stable_o  = r_stable;

  // Synchronise the raw switches and qualify any difference for DEB_CYCLES edges
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
      if (accept_o) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sw_input_periph.sv
//============================================================================
// Module : sw_input_periph
// Brief  : Memory-mapped switch input peripheral. Debounced switch value,
//          sticky change flag with W1C / read-clear, level interrupt and a
//          1-cycle-latency register read port.
//          Optional feature macro: SW_INPUT_CHG_CNT_EN (16-bit saturating
//          change counter at register 3, clear-on-read).
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module sw_input_periph
  import sw_input_periph_pkg::*;
#(
  parameter int SW_W       = 10,
  parameter int DEB_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic [SW_W-1:0] SW_i,
  input  logic            rd_en_i,
  input  logic            we_i,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     wd_i,
  output logic [31:0]     rd_data_o,
  output logic            irq_o,
  output logic [SW_W-1:0] stable_o
);

  logic [SW_W-1:0] w_sync2;
  logic            w_accept;
  logic            r_chg;
  logic            r_ie;
  logic [31:0]     w_rd_mux;
  logic [15:0]     w_cnt_val;
  logic            w_rd_value;
  logic            w_wr_ctrl;
  logic            w_unused_ok;

  sw_debounce #(
    .SW_W       (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk_i    (clk_i),
    .reset    (reset),
    .sw_i     (SW_i),
    .sync_o   (w_sync2),
    .stable_o (stable_o),
    .accept_o (w_accept)
  );

  assign w_rd_value  = rd_en_i && (addr_i == SW_REG_VALUE);
  assign w_wr_ctrl   = we_i && (addr_i == SW_REG_CTRL);
  assign w_unused_ok = &{1'b0, wd_i[31:2]};

  // Sticky change flag and interrupt enable; a new acceptance beats any clear
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_chg <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ie <= wd_i[SW_CTRL_IE];
      end
      if (w_accept) begin
        r_chg <= 1'b1;
      end else if (w_rd_value || (w_wr_ctrl && wd_i[SW_CTRL_CHG])) begin
        r_chg <= 1'b0;
      end
    end
  end

`ifdef SW_INPUT_CHG_CNT_EN
  logic [15:0] r_chg_cnt;
  logic        w_rd_cnt;

  assign w_rd_cnt  = rd_en_i && (addr_i == SW_REG_CNT);
  assign w_cnt_val = r_chg_cnt;

  // Saturating acceptance counter; read clears, a same-cycle increment yields 1
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_chg_cnt <= '0;
    end else if (w_accept && w_rd_cnt) begin
      r_chg_cnt <= 16'd1;
    end else if (w_accept) begin
      if (r_chg_cnt != 16'hFFFF) begin
        r_chg_cnt <= r_chg_cnt + 16'd1;
      end
    end else if (w_rd_cnt) begin
      r_chg_cnt <= '0;
    end
  end
`else
  assign w_cnt_val = 16'd0;
`endif

  // Read mux over pre-edge register values, zero-extended
  always_comb begin
    w_rd_mux = '0;
    case (addr_i)
      SW_REG_VALUE: w_rd_mux = 32'(stable_o);
      SW_REG_CTRL:  w_rd_mux = ctrl_word(r_ie, r_chg);
      SW_REG_RAW:   w_rd_mux = 32'(w_sync2);
      SW_REG_CNT:   w_rd_mux = 32'(w_cnt_val);
      default:      w_rd_mux = '0;
    endcase
  end

  // Registered read data held until the next read; registered interrupt level
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rd_data_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (rd_en_i) begin
        rd_data_o <= w_rd_mux;
      end
      irq_o <= r_chg & r_ie;
    end
  end

endmodule

`default_nettype wire
